// File: rtl/game_pkg.sv
// Shared types and constants for the speed-tick selector.
package game_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} tick_state_t;

    localparam int LEVEL_W    = 2;
    localparam int NUM_SPEEDS = 4;

endpackage

// File: rtl/speed_tick_select_edge_sync.sv
// One divided clock brought into the clk domain, with a rising-edge strobe.
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q,  hist_d;

    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
        end
    end

    assign rise = sync2_q & ~hist_q;

endmodule

// File: rtl/speed_tick_select.sv
// Picks one divided-clock rate by game level and emits a registered move_tick;
// owns the game FSM, the per-level move counter and the level register.
module speed_tick_select
    import game_pkg::*;
#(
    parameter int TICKS_PER_LEVEL = 16,
    parameter int MAX_LEVEL       = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_SPEEDS-1:0] speed,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  level_up,
    output logic                  move_tick,
    output logic [LEVEL_W-1:0]    level,
    output logic                  running
);

    localparam int                   CNT_W    = $clog2(TICKS_PER_LEVEL);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TICKS_PER_LEVEL - 1);
    localparam logic [LEVEL_W-1:0]   LVL_MAX  = LEVEL_W'(MAX_LEVEL);

    logic [NUM_SPEEDS-1:0] rise;

    for (genvar i = 0; i < NUM_SPEEDS; i++) begin : g_sync
        edge_sync u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (speed[i]),
            .rise  (rise[i])
        );
    end

    tick_state_t          state_q, state_d;
    logic                 move_tick_q, move_tick_d;
    logic                 running_q, running_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [LEVEL_W-1:0]   sel_idx;
    logic                 sel_rise;
    logic                 auto_inc;
    logic                 bump;

    // Level 0 follows the slowest clock, the top level the fastest.
    assign sel_idx  = LEVEL_W'(NUM_SPEEDS - 1) - level_q;
    assign sel_rise = rise[sel_idx];

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        cnt_d       = cnt_q;
        move_tick_d = (state_q == RUN) && !pause && sel_rise;
        auto_inc    = move_tick_q && (cnt_q == CNT_LAST) && (level_q != LVL_MAX);
        bump        = auto_inc || (level_up && (state_q != IDLE));

        if (start) begin
            state_d = RUN;
            level_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                RUN:     if (pause)  state_d = PAUSED;
                PAUSED:  if (!pause) state_d = RUN;
                default: state_d = IDLE;
            endcase

            // A forced level-up landing on the wrapping tick still moves one level.
            if (bump) begin
                level_d = (level_q == LVL_MAX) ? level_q : level_q + LEVEL_W'(1);
                cnt_d   = '0;
            end else if (move_tick_q) begin
                cnt_d = (level_q == LVL_MAX) ? '0 : cnt_q + CNT_W'(1);
            end
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            move_tick_q <= 1'b0;
            running_q   <= 1'b0;
            level_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            move_tick_q <= move_tick_d;
            running_q   <= running_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
        end
    end

    assign move_tick = move_tick_q;
    assign level     = level_q;
    assign running   = running_q;

endmodule

// File: tb/tb_speed_tick_select.sv
// Directed bench for speed_tick_select with a cycle-level reference model.
module tb_speed_tick_select;

    localparam int TPL  = 4;
    localparam int MAXL = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] speed = 4'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       level_up = 1'b0;
    logic       move_tick;
    logic [1:0] level;
    logic       running;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int cyc    = 0;
    bit chk_en = 0;
    logic [3:0] spd_prev = 4'b0;

    speed_tick_select #(.TICKS_PER_LEVEL(TPL), .MAX_LEVEL(MAXL)) dut (
        .clk       (clk),
        .reset     (reset),
        .speed     (speed),
        .start     (start),
        .pause     (pause),
        .level_up  (level_up),
        .move_tick (move_tick),
        .level     (level),
        .running   (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Divider-style square waves: speed[i] half-period is 10*2^i clocks.
    initial forever begin
        @(negedge clk);
        spd_prev = speed;
        cyc++;
        for (int i = 0; i < 4; i++) speed[i] = ((cyc / (10 << i)) % 2) == 1;
    end

    // Reference model: states 0 idle, 1 run, 2 paused; h1..h3 are the speed
    // values seen at the last three edges (zeroed by reset).
    int         m_state = 0, m_level = 0, m_cnt = 0, m_sel = 0;
    bit         m_tick = 0, m_new = 0, m_was_idle = 0;
    logic [3:0] h1 = 0, h2 = 0, h3 = 0;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_state = 0; m_level = 0; m_cnt = 0; m_tick = 0;
            h1 = 0; h2 = 0; h3 = 0;
        end else begin
            // A rise first sampled two edges ago becomes a tick on this edge.
            m_sel      = 3 - m_level;
            m_new      = (m_state == 1) && !pause && h2[m_sel] && !h3[m_sel];
            m_was_idle = (m_state == 0);
            if (start) begin
                m_state = 1; m_level = 0; m_cnt = 0;
            end else begin
                if (m_state == 1 && pause) m_state = 2;
                else if (m_state == 2 && !pause) m_state = 1;
                if (level_up && !m_was_idle) begin
                    m_level = (m_level < MAXL) ? m_level + 1 : MAXL;
                    m_cnt   = 0;
                end else if (m_tick) begin
                    if (m_level == MAXL) m_cnt = 0;
                    else if (m_cnt == TPL - 1) begin m_cnt = 0; m_level++; end
                    else m_cnt++;
                end
            end
            m_tick = m_new;
            h3 = h2; h2 = h1; h1 = speed;
        end
    end

    initial forever begin
        @(negedge clk);
        if (move_tick) pulses++;
        if (chk_en) begin
            chk("model_move_tick", int'(move_tick), int'(m_tick));
            chk("model_level", int'(level), m_level);
            chk("model_running", int'(running), int'(m_state == 1));
        end
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic wait_rise(input int i);
        bit found = 0;
        for (int n = 0; n < 400 && !found; n++) begin
            step();
            if (speed[i] && !spd_prev[i]) found = 1;
        end
        chk($sformatf("wait_rise%0d_timeout", i), int'(found), 1);
    endtask

    // After a rise: quiet for two edges, then the expected pulse value.
    task automatic latency(input string nm, input int exp_tick);
        step(); chk({nm, "_k0"}, int'(move_tick), 0);
        step(); chk({nm, "_k1"}, int'(move_tick), 0);
        step(); chk({nm, "_k2"}, int'(move_tick), exp_tick);
    endtask

    task automatic run_ticks(input int n);
        int got = 0;
        for (int c = 0; c < 200 * n && got < n; c++) begin
            step();
            if (move_tick) got++;
        end
        chk("run_ticks_count", got, n);
    endtask

    int p0;

    initial begin
        step(); step();
        chk_en = 1;
        step();
        chk("reset_move_tick", int'(move_tick), 0);
        chk("reset_level", int'(level), 0);
        chk("reset_running", int'(running), 0);
        reset = 0;

        // 1: idle produces nothing, then start at level 0
        p0 = pulses;
        repeat (30) step();
        chk("idle_no_ticks", pulses - p0, 0);
        start = 1; step(); start = 0;
        chk("start_running", int'(running), 1);
        chk("start_level", int'(level), 0);
        wait_rise(3);
        latency("l0_tick", 1);

        // 2: three more level-0 ticks move to level 1, rate follows speed[2]
        run_ticks(3);
        step();
        chk("level_after_4", int'(level), 1);
        wait_rise(2);
        latency("l1_tick", 1);
        run_ticks(2);

        // 5: level_up coinciding with the wrapping tick moves only one level
        wait_rise(2);
        step(); step(); step();
        chk("coincide_tick", int'(move_tick), 1);
        level_up = 1; step(); level_up = 0;
        chk("coincide_level", int'(level), 2);
        step();
        chk("coincide_level_hold", int'(level), 2);

        // 3: saturation at level 3
        run_ticks(4);
        step();
        chk("level_3", int'(level), 3);
        run_ticks(8);
        step();
        chk("sat_after_8", int'(level), 3);
        level_up = 1; step(); level_up = 0;
        step();
        chk("sat_level_up", int'(level), 3);

        // 4: restart from run, then pause across three speed[3] rises
        start = 1; step(); start = 0;
        chk("restart_level", int'(level), 0);
        pause = 1;
        p0 = pulses;
        for (int r = 0; r < 3; r++) wait_rise(3);
        repeat (4) step();
        chk("pause_no_ticks", pulses - p0, 0);
        chk("pause_running", int'(running), 0);
        chk("pause_level", int'(level), 0);
        pause = 0;
        step();
        chk("unpause_running", int'(running), 1);
        wait_rise(3);
        latency("unpause_tick", 1);

        // 6: reset mid-run at level 2
        level_up = 1; step(); level_up = 0; step();
        level_up = 1; step(); level_up = 0; step();
        chk("pre_reset_level", int'(level), 2);
        reset = 1; step(); reset = 0;
        chk("rst_move_tick", int'(move_tick), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_running", int'(running), 0);
        p0 = pulses;
        repeat (200) step();
        chk("post_reset_no_ticks", pulses - p0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
